// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file write-port control slice.
//   XLEN_DEF    default datapath width
//   REG_ADDR_W  register address width
//   REG_CNT     number of architectural registers
//   lu_result_t long-latency unit result record {addr, data}
package rf_ctrl_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_CNT    = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN_DEF-1:0]   data;
  } lu_result_t;

endpackage

// File: rtl/rf_result_fifo.sv
// Small FIFO buffering long-latency unit results until the write port is free.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data     enqueue one entry (caller guarantees !full or same-cycle pop)
//   pop                 dequeue the head (caller guarantees !empty)
//   full, empty         occupancy flags
//   head                current head entry, valid when !empty
// Push and pop may occur together even when full: the pop frees the slot the
// push writes, and order is preserved.
module rf_result_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int WIDTH      = 37
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are meaningful, so clearing data would only cost flops.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register file's single write port between the writeback
// stage (WB) and buffered long-latency unit (LU) results, and tracks
// outstanding LU destinations for decode hazard detection.
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_wb_wren/i_wb_rd_addr/i_wb_rd_data   WB write request (rd 0 is no request)
//   i_lu_issue/i_lu_issue_rd              decode dispatches an LU op
//   i_lu_valid/i_lu_rd_addr/i_lu_data     LU result, o_lu_ready handshake
//   i_rs1_addr/i_rs2_addr/i_dec_rd_addr   decode operands checked by o_sb_hazard
//   o_pipe_stall                          one-cycle freeze forcing an LU write
//   o_rd_wren/o_rd_addr/o_rd_data         regfile write port (combinational)
module rf_wport_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wb_wren,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic [XLEN-1:0]       i_wb_rd_data,
  input  logic                  i_lu_issue,
  input  logic [REG_ADDR_W-1:0] i_lu_issue_rd,
  input  logic                  i_lu_valid,
  input  logic [REG_ADDR_W-1:0] i_lu_rd_addr,
  input  logic [XLEN-1:0]       i_lu_data,
  output logic                  o_lu_ready,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_dec_rd_addr,
  output logic                  o_sb_hazard,
  output logic                  o_pipe_stall,
  output logic                  o_rd_wren,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int ENT_W = REG_ADDR_W + XLEN;

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LU} grant_e;

  grant_e                grant;
  logic                  wb_req;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENT_W-1:0]      head;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;
  logic [REG_CNT-1:0]    pending;
  logic [REG_CNT-1:0]    pending_set;
  logic [REG_CNT-1:0]    pending_clr;
  logic [CNT_W-1:0]      starve_cnt;
  logic [CNT_W-1:0]      starve_cnt_next;
  logic                  stall_q;

  assign wb_req                 = i_wb_wren && (i_wb_rd_addr != '0);
  assign {head_addr, head_data} = head;

  // A forced stall always finds the FIFO non-empty (the counter only advances
  // while it holds data), but never grant WB during a freeze regardless.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = GNT_NONE;
    if (!i_rst) begin
      if (stall_q) begin
        if (!fifo_empty) grant = GNT_LU;
      end else if (wb_req) begin
        grant = GNT_WB;
      end else if (!fifo_empty) begin
        grant = GNT_LU;
      end
    end
  end

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = '0;
    o_rd_data = '0;
    case (grant)
      GNT_WB: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_wb_rd_addr;
        o_rd_data = i_wb_rd_data;
      end
      GNT_LU: begin
        o_rd_wren = 1'b1;
        o_rd_addr = head_addr;
        o_rd_data = head_data;
      end
      default: ;
    endcase
  end

  // Pop happens before push, so a full FIFO can accept when its head leaves.
  assign fifo_pop   = (grant == GNT_LU);
  assign o_lu_ready = !i_rst && (!fifo_full || fifo_pop);
  // rd 0 results complete the handshake but are discarded.
  assign fifo_push  = i_lu_valid && o_lu_ready && (i_lu_rd_addr != '0);

  rf_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (ENT_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (fifo_push),
    .push_data ({i_lu_rd_addr, i_lu_data}),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Starvation: count consecutive WB wins over a waiting head, saturating.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_next = '0;
    end else if (grant == GNT_WB && starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    pending_set[i_lu_issue_rd] = i_lu_issue;
    pending_clr[head_addr]     = fifo_pop;
    pending_set[0]             = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
      pending    <= '0;
    end else begin
      starve_cnt <= starve_cnt_next;
      // The stall cycle pops the head and clears the counter, so this can
      // never hold for two cycles in a row; the !stall_q term makes it explicit.
      stall_q    <= !stall_q && (starve_cnt_next == CNT_W'(STARVE_MAX));
      pending    <= ((pending & ~pending_clr) | pending_set) & {{(REG_CNT-1){1'b1}}, 1'b0};
    end
  end

  assign o_pipe_stall = stall_q;
  // Registered bits only: the hazard stays up during the clearing write, which
  // is safe because the regfile commits on the falling edge.
  assign o_sb_hazard  = pending[i_rs1_addr] | pending[i_rs2_addr] | pending[i_dec_rd_addr];

  a_no_issue_on_hazard: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_lu_issue && o_sb_hazard));

endmodule
